encoded_frame_tx: RTL and testbench
===================================

// Module: encoded_frame_tx
// PURPOSE
// - Downstream stage of the rate-1/2 convolutional encoder path. Accepts one encoded frame
//   (default 64 bits = 8 bytes) and streams it byte-by-byte into async_transmitter.
// - Optional header byte before the payload and XOR checksum byte after it.
// - Replaces push-button byte stepping with a valid/ready frame handshake and a TxD_busy-paced byte loop.
// PARAMETERS
// - FRAME_BYTES   8     payload bytes per frame (1..16)
// - SEND_HEADER   1     1: transmit HEADER_BYTE before the payload
// - HEADER_BYTE   8'hA5 frame marker value
// - SEND_CSUM     1     1: transmit the XOR of all payload bytes after the payload
// - ACK_TIMEOUT   16    max cycles to wait for tx_busy to rise after tx_start
// PORTS
// - clk          in   1               system clock
// - reset        in   1               synchronous, active-high reset
// - frame_data   in   FRAME_BYTES*8   encoded frame; byte k = frame_data[8k+7:8k]
// - frame_valid  in   1               frame_data valid
// - frame_ready  out  1               block idle; frame accepted when valid&&ready
// - tx_data      out  8               byte to async_transmitter TxD_data
// - tx_start     out  1               one-cycle start pulse to TxD_start
// - tx_busy      in   1               async_transmitter TxD_busy
// - frame_done   out  1               one-cycle pulse after the last byte's tx_busy falls
// - tx_error     out  1               one-cycle pulse on ack timeout (frame aborted)
// BEHAVIOUR
// - Reset: state=IDLE, frame_ready=1, tx_data=0, tx_start=0, frame_done=0, tx_error=0, byte index=0, csum=0.
//   Reset mid-frame aborts immediately; tx_start is never asserted in the cycle after reset.
// - Accept: on valid&&ready, register frame_data into a shift register, clear csum, drop frame_ready.
//   The input is not sampled again until IDLE.
// - Byte order: header (if enabled), payload bytes 0..FRAME_BYTES-1, csum (if enabled).
//   TOTAL = FRAME_BYTES + SEND_HEADER + SEND_CSUM.
// - FSM: IDLE -> LOAD -> START -> WAIT_ACK -> WAIT_DONE -> (LOAD | FINISH) ; FINISH -> IDLE.
//   LOAD: select the next byte into tx_data. For payload bytes, csum ^= byte and shift the register right by 8.
//   START: tx_start=1 for exactly one cycle. tx_data is held stable from LOAD until WAIT_DONE exits.
//   WAIT_ACK: wait for tx_busy=1. If ACK_TIMEOUT cycles pass without it, pulse tx_error and go to IDLE.
//     No frame_done is issued on timeout.
//   WAIT_DONE: wait for tx_busy=0. Then go to LOAD if bytes remain, else FINISH.
//   FINISH: frame_done=1 for one cycle, then IDLE with frame_ready=1.
// - Latency: accept -> first tx_start = 2 cycles. Minimum gap from tx_busy falling to the next tx_start = 2 cycles.
// - tx_busy already high in START: treated as the ack in the next cycle; no extra pulse is issued.
// - Byte counter width is $clog2(TOTAL+1); it stops at TOTAL and never wraps.
// - frame_valid deasserting mid-frame has no effect. At most one frame is in flight.
// STRUCTURE
// - Package enc_tx_pkg holds the state enum typedef tx_state_t and localparams
//   HDR_DEFAULT=8'hA5 and MAX_FRAME_BYTES=16.
// - Single module, no sub-modules. Ack timeout counter and byte counter are inline registers.
// - Instantiated in top between encode_buffer (frame_data) and async_transmitter TX.
// TESTING
// - Use a behavioural TX model with busy rising 1 cycle after start and held for 20 cycles.
// - Default params, frame_data=64'h0807_0605_0403_0201
//   -> bytes A5,01,02,03,04,05,06,07,08,08 (csum 0x08); one frame_done; 10 tx_start pulses.
// - SEND_HEADER=0, SEND_CSUM=0, frame 64'hFFEE_DDCC_BBAA_9988
//   -> exactly 8 bytes 88,99,AA,BB,CC,DD,EE,FF; frame_ready low for the whole transfer.
// - TX model never raises busy -> tx_error pulses ACK_TIMEOUT+1 cycles after tx_start;
//   no frame_done; frame_ready=1 the next cycle.
// - Assert reset during byte 3's WAIT_DONE -> outputs return to reset values; no further tx_start;
//   a new frame then transmits from the header.
// - Hold frame_valid high continuously with two frames back-to-back
//   -> second frame is accepted only after frame_done; no byte interleaving.
// - tx_data is checked stable between each tx_start and the following tx_busy fall.

Source files
------------

// File: rtl/enc_tx_pkg.sv
// rtl/enc_tx_pkg.sv - shared state type and constants for encoded_frame_tx
package enc_tx_pkg;

    localparam logic [7:0] HDR_DEFAULT     = 8'hA5;
    localparam int         MAX_FRAME_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_FINISH
    } tx_state_t;

endpackage

// File: rtl/encoded_frame_tx.sv
// rtl/encoded_frame_tx.sv - streams one encoded frame byte-by-byte into a busy-paced UART transmitter
module encoded_frame_tx
    import enc_tx_pkg::*;
#(
    parameter int         FRAME_BYTES = 8,
    parameter bit         SEND_HEADER = 1'b1,
    parameter logic [7:0] HEADER_BYTE = HDR_DEFAULT,
    parameter bit         SEND_CSUM   = 1'b1,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FRAME_BYTES*8-1:0] frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     frame_done,
    output logic                     tx_error
);

    localparam int TOTAL = FRAME_BYTES + int'(SEND_HEADER) + int'(SEND_CSUM);
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);
    localparam logic [IDX_W-1:0] PAY_END   = IDX_W'(FRAME_BYTES + int'(SEND_HEADER));
    localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

    tx_state_t                state_q, state_d;
    logic [FRAME_BYTES*8-1:0] sr_q, sr_d;
    logic [7:0]               csum_q, csum_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ACK_W-1:0]         ack_cnt_q, ack_cnt_d;
    logic                     tx_error_q, tx_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (frame_valid) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_START;
            ST_START:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = (idx_q == TOTAL_IDX) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Byte index counts bytes already placed on tx_data; it saturates at TOTAL.
    always_comb begin
        sr_d       = sr_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        idx_d      = idx_q;
        ack_cnt_d  = ack_cnt_q;
        tx_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    sr_d   = frame_data;
                    csum_d = '0;
                    idx_d  = '0;
                end
            end
            ST_LOAD: begin
                if (SEND_HEADER && idx_q == '0) begin
                    tx_data_d = HEADER_BYTE;
                end else if (idx_q < PAY_END) begin
                    tx_data_d = sr_q[7:0];
                    csum_d    = csum_q ^ sr_q[7:0];
                    sr_d      = sr_q >> 8;
                end else begin
                    tx_data_d = csum_q;
                end
                if (idx_q != TOTAL_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_START: ack_cnt_d = '0;
            ST_WAIT_ACK: begin
                if (!tx_busy) begin
                    if (ack_cnt_q == ACK_LAST) begin
                        tx_error_d = 1'b1;
                    end else begin
                        ack_cnt_d = ack_cnt_q + ACK_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            idx_q      <= '0;
            ack_cnt_q  <= '0;
            tx_error_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            idx_q      <= idx_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_error_q <= tx_error_d;
        end
    end

    always_comb begin
        frame_ready = (state_q == ST_IDLE);
        tx_start    = (state_q == ST_START);
        frame_done  = (state_q == ST_FINISH);
        tx_data     = tx_data_q;
        tx_error    = tx_error_q;
    end

endmodule

// File: tb/tb_encoded_frame_tx.sv
// tb/tb_encoded_frame_tx.sv - self-checking bench for encoded_frame_tx
module tb_encoded_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [63:0] fd0, fd1;
    logic        fv0, fv1, fr0, fr1, ts0, ts1, fdn0, fdn1, te0, te1;
    logic [7:0]  txd0, txd1;
    logic        busy0, busy1, ack_en0;
    int          bcnt0, bcnt1;

    encoded_frame_tx dut (
        .clk(clk), .reset(reset), .frame_data(fd0), .frame_valid(fv0), .frame_ready(fr0),
        .tx_data(txd0), .tx_start(ts0), .tx_busy(busy0), .frame_done(fdn0), .tx_error(te0)
    );

    encoded_frame_tx #(.SEND_HEADER(1'b0), .SEND_CSUM(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .frame_data(fd1), .frame_valid(fv1), .frame_ready(fr1),
        .tx_data(txd1), .tx_start(ts1), .tx_busy(busy1), .frame_done(fdn1), .tx_error(te1)
    );

    // Transmitter model: busy rises the cycle after start and stays high for 20 cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy0 <= 1'b0; bcnt0 <= 0;
        end else if (ts0 && ack_en0) begin
            busy0 <= 1'b1; bcnt0 <= 20;
        end else if (bcnt0 == 1) begin
            busy0 <= 1'b0; bcnt0 <= 0;
        end else if (bcnt0 != 0) begin
            bcnt0 <= bcnt0 - 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            busy1 <= 1'b0; bcnt1 <= 0;
        end else if (ts1) begin
            busy1 <= 1'b1; bcnt1 <= 20;
        end else if (bcnt1 == 1) begin
            busy1 <= 1'b0; bcnt1 <= 0;
        end else if (bcnt1 != 0) begin
            bcnt1 <= bcnt1 - 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int starts0 = 0, done0 = 0, err0 = 0, starts1 = 0, done1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [63:0] frame;
        logic [7:0]  csum;
    } vec_t;
    vec_t vec[5];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic monitor0();
        logic [7:0] held = '0;
        logic [7:0] exp;
        bit inflight = 0, stable = 1, prev_start = 0, prev_busy = 0, have_fall = 0;
        int cyc = 0, last_fall = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                inflight = 0; prev_start = 0; prev_busy = 0; have_fall = 0;
                continue;
            end
            if (ts0) begin
                chk("start_single_cycle", prev_start, 0);
                if (have_fall) chk("busy_fall_to_start_gap", cyc - last_fall, 2);
                have_fall = 0;
                starts0++;
                if (q0.size() == 0) begin
                    chk("unexpected_tx_start", 1, 0);
                end else begin
                    exp = q0.pop_front();
                    chk("tx_byte", txd0, exp);
                end
                held = txd0; inflight = 1; stable = 1;
            end else if (inflight) begin
                if (txd0 !== held) stable = 0;
                if (prev_busy && !busy0) begin
                    chk("tx_data_stable", stable, 1);
                    inflight = 0; have_fall = 1; last_fall = cyc;
                end
            end
            if (fdn0) begin done0++; have_fall = 0; end
            if (te0) begin err0++; inflight = 0; have_fall = 0; end
            prev_start = ts0; prev_busy = busy0;
        end
    endtask

    task automatic monitor1();
        logic [7:0] exp;
        forever begin
            @(posedge clk); #1;
            if (reset) continue;
            if (ts1) begin
                starts1++;
                if (q1.size() == 0) begin
                    chk("unexpected_tx_start_raw", 1, 0);
                end else begin
                    exp = q1.pop_front();
                    chk("tx_byte_raw", txd1, exp);
                end
            end
            if (fdn1) done1++;
        end
    endtask

    task automatic push0(input logic [63:0] f, input logic [7:0] csum);
        q0.push_back(8'hA5);
        for (int k = 0; k < 8; k++) q0.push_back(f[8*k +: 8]);
        q0.push_back(csum);
    endtask

    task automatic send0(input logic [63:0] f);
        int n = 0;
        @(negedge clk); fd0 = f; fv0 = 1'b1;
        while (!fr0 && n < 2000) begin @(negedge clk); n++; end
        chk("accept_wait_bound", n < 2000, 1);
        @(posedge clk); #1;
        chk("accept_latency_load", ts0, 0);
        @(negedge clk); fv0 = 1'b0; fd0 = '0;
        @(posedge clk); #1;
        chk("accept_latency_start", ts0, 1);
    endtask

    task automatic wait_done0(input int d);
        int n = 0;
        while (done0 == d && n < 3000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s, d, e, n, i_err;
        bit seen, rdy18;
        logic [63:0] fr;

        vec[0] = '{64'h0807_0605_0403_0201, 8'h08};
        vec[1] = '{64'hFFEE_DDCC_BBAA_9988, 8'h00};
        vec[2] = '{64'h0000_0000_0000_0000, 8'h00};
        vec[3] = '{64'h8040_2010_0804_0201, 8'hFF};
        vec[4] = '{64'hDEAD_BEEF_0000_0001, 8'h23};

        reset = 1'b1; fv0 = 1'b0; fv1 = 1'b0; fd0 = '0; fd1 = '0; ack_en0 = 1'b1;
        fork
            monitor0();
            monitor1();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {fr0, txd0, ts0, fdn0, te0}, {1'b1, 8'h00, 3'b000});
        chk("reset_outputs_raw", {fr1, txd1, ts1, fdn1, te1}, {1'b1, 8'h00, 3'b000});
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("no_start_after_reset_release", ts0, 0);

        for (int t = 0; t < 5; t++) begin
            s = starts0; d = done0;
            push0(vec[t].frame, vec[t].csum);
            send0(vec[t].frame);
            wait_done0(d);
            chk("frame_tx_starts", starts0 - s, 10);
            chk("frame_done_count", done0 - d, 1);
            chk("scoreboard_drained", q0.size(), 0);
        end

        // Raw variant: no header, no checksum, ready low for the whole transfer.
        fr = 64'hFFEE_DDCC_BBAA_9988;
        s = starts1; d = done1;
        for (int k = 0; k < 8; k++) q1.push_back(fr[8*k +: 8]);
        @(negedge clk); fd1 = fr; fv1 = 1'b1;
        @(posedge clk);
        @(negedge clk); fv1 = 1'b0; fd1 = '0;
        seen = 0; n = 0;
        while (done1 == d && n < 3000) begin
            if (fr1) seen = 1;
            @(negedge clk); n++;
        end
        chk("raw_ready_low_during_frame", seen, 0);
        chk("raw_tx_starts", starts1 - s, 8);
        chk("raw_done_count", done1 - d, 1);
        chk("raw_scoreboard_drained", q1.size(), 0);

        // Ack timeout: the transmitter never raises busy.
        ack_en0 = 1'b0;
        s = starts0; d = done0; e = err0;
        q0.push_back(8'hA5);
        send0(vec[0].frame);
        i_err = 0; rdy18 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (te0 && i_err == 0) i_err = i;
            if (i == 18) rdy18 = fr0;
        end
        chk("timeout_error_latency", i_err, 17);
        chk("timeout_ready_next_cycle", rdy18, 1);
        @(negedge clk); ack_en0 = 1'b1;
        chk("timeout_error_count", err0 - e, 1);
        chk("timeout_no_frame_done", done0 - d, 0);
        chk("timeout_single_start", starts0 - s, 1);
        chk("timeout_scoreboard_drained", q0.size(), 0);

        // Reset while the third byte is in WAIT_DONE.
        s = starts0;
        q0.push_back(8'hA5); q0.push_back(8'h01); q0.push_back(8'h02);
        send0(vec[0].frame);
        n = 0;
        while (starts0 - s < 3 && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!busy0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_frame_outputs", {fr0, txd0, ts0, fdn0, te0}, {1'b1, 8'h00, 3'b000});
        @(negedge clk); reset = 1'b0;
        s = starts0;
        repeat (40) @(negedge clk);
        chk("no_start_after_mid_reset", starts0 - s, 0);
        chk("mid_reset_scoreboard_drained", q0.size(), 0);
        s = starts0; d = done0;
        push0(vec[3].frame, vec[3].csum);
        send0(vec[3].frame);
        wait_done0(d);
        chk("post_reset_frame_starts", starts0 - s, 10);
        chk("post_reset_frame_done", done0 - d, 1);

        // Back-to-back frames with frame_valid held high.
        s = starts0; d = done0;
        push0(vec[1].frame, vec[1].csum);
        push0(vec[4].frame, vec[4].csum);
        @(negedge clk); fd0 = vec[1].frame; fv0 = 1'b1;
        @(posedge clk);
        @(negedge clk); fd0 = vec[4].frame;
        n = 0;
        while (!fr0 && n < 3000) begin @(negedge clk); n++; end
        chk("b2b_second_accept_after_done", done0 - d, 1);
        @(posedge clk);
        @(negedge clk); fv0 = 1'b0; fd0 = '0;
        wait_done0(d + 1);
        chk("b2b_tx_starts", starts0 - s, 20);
        chk("b2b_done_count", done0 - d, 2);
        chk("b2b_scoreboard_drained", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
